// File: rtl/dm_resp_if.sv
// Request/response bus between an initiator and the dm_resp memory responder.
interface dm_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/dm_resp.sv
// Single-port word memory answering one request at a time after a fixed number
// of wait states; misaligned or out-of-range addresses respond with err.
module dm_resp #(
  parameter int DEPTH_LOG2  = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  dm_resp_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // With no wait states an accepted request goes straight to RESP.
  localparam logic [1:0] S_ACC    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  resp;
  logic                  addr_err;
  logic                  wr_commit;
  logic [DEPTH_LOG2-1:0] idx;

  assign accept    = bus.req && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign resp      = (state_q == S_RESP);
  assign idx       = addr_q[DEPTH_LOG2+1:2];
  assign addr_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign wr_commit = resp && we_q && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = S_ACC;
          cnt_d   = CNT_INIT;
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage is never cleared; a reset edge only blocks the commit.
  always_ff @(posedge clk) begin
    if (rst && wr_commit) mem[idx] <= wdata_q;
  end

  // Asynchronous read so a write committed on the edge that ends RESP is
  // visible to a read whose RESP immediately follows.
  assign bus.ready = resp;
  assign bus.err   = resp && addr_err;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = (resp && !we_q && !addr_err) ? mem[idx] : 32'd0;
endmodule

// File: tb/tb_dm_resp.sv
// Directed bench: three responders (2, 0 and 3 wait states) on one clock and reset.
module tb_dm_resp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_resp_if ifa ();
  dm_resp_if ifb ();
  dm_resp_if ifc ();

  dm_resp #(.DEPTH_LOG2(5), .WAIT_CYCLES(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  dm_resp #(.DEPTH_LOG2(5), .WAIT_CYCLES(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  dm_resp #(.DEPTH_LOG2(5), .WAIT_CYCLES(3)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated transaction on the 2-wait-state unit; inputs are scrambled
  // after acceptance so a missing latch shows up as wrong data.
  task automatic txn_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
    logic quiet;
    quiet = 1'b1; lat = 0; rd = 32'd0; e = 1'b0;
    ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = d;
    @(posedge clk); #1;
    ifa.req = 1'b0; ifa.we = ~w; ifa.addr = 32'hFFFF_FFF0; ifa.wdata = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ifa.ready) begin
        lat = k; rd = ifa.rdata; e = ifa.err;
        break;
      end
      if (ifa.rdata != 32'd0 || ifa.err) quiet = 1'b0;
    end
    chk("quiet_outside_resp", 32'(quiet), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_a(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    txn_a(w, a, d, rd, e, lat);
    chk({tag, "_lat"},   32'(lat), 32'd3);
    chk({tag, "_err"},   32'(e),   32'(exp_err));
    chk({tag, "_rdata"}, rd,       exp_rd);
  endtask

  initial begin
    logic [2:0] rdy_bits;
    int         nrdy;
    int         first;

    rst = 1'b0;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = 32'd0; ifa.wdata = 32'd0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = 32'd0; ifb.wdata = 32'd0;
    ifc.req = 1'b0; ifc.we = 1'b0; ifc.addr = 32'd0; ifc.wdata = 32'd0;
    // req held high during reset must be ignored
    ifa.req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ifa.ready), 32'd0);
    chk("rst_busy",  32'(ifa.busy),  32'd0);
    chk("rst_err",   32'(ifa.err),   32'd0);
    chk("rst_rdata", ifa.rdata,      32'd0);
    ifa.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Preload and basic write/read
    do_a("init_w0", 1'b1, 32'h0, 32'h1111_0000, 32'd0, 1'b0);
    do_a("init_w1", 1'b1, 32'h4, 32'h0BAD_F00D, 32'd0, 1'b0);
    do_a("wr_8",    1'b1, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_a("rd_8",    1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, 1'b0);

    // Back-to-back: read accepted in the write's RESP cycle
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h4; ifa.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    ifa.we = 1'b0; ifa.wdata = 32'h0;
    rdy_bits = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rdy_bits[k] = ifa.ready;
    end
    chk("b2b_wr_ready", 32'(rdy_bits), 32'h4);
    chk("b2b_wr_err",   32'(ifa.err),  32'd0);
    @(posedge clk); #1;
    ifa.req = 1'b0;
    @(negedge clk);
    chk("b2b_busy_between", 32'(ifa.busy), 32'd1);
    rdy_bits = {2'b00, ifa.ready};
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      rdy_bits[k] = ifa.ready;
    end
    chk("b2b_rd_ready", 32'(rdy_bits), 32'h4);
    chk("b2b_rd_rdata", ifa.rdata,     32'h1234_5678);
    @(posedge clk); #1;

    // Misaligned and out-of-range accesses
    do_a("wr_misal",  1'b1, 32'h6,  32'hFFFF_FFFF, 32'd0,         1'b1);
    do_a("rd_w1",     1'b0, 32'h4,  32'h0,         32'h1234_5678, 1'b0);
    do_a("rd_oor",    1'b0, 32'h80, 32'h0,         32'd0,         1'b1);
    do_a("wr_top",    1'b1, 32'h7C, 32'hCAFE_F00D, 32'd0,         1'b0);
    do_a("rd_top",    1'b0, 32'h7C, 32'h0,         32'hCAFE_F00D, 1'b0);
    do_a("wr_oor",    1'b1, 32'h80, 32'h7777_7777, 32'd0,         1'b1);
    do_a("rd_w0_oor", 1'b0, 32'h0,  32'h0,         32'h1111_0000, 1'b0);

    // Reset during WAIT abandons the write
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h0; ifa.wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    ifa.req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifa.ready) nrdy++;
      if (k == 0) chk("rstmid_busy", 32'(ifa.busy), 32'd0);
    end
    chk("rstmid_no_ready", 32'(nrdy), 32'd0);
    @(posedge clk); #1;
    do_a("rstmid_rd_w0", 1'b0, 32'h0, 32'h0, 32'h1111_0000, 1'b0);

    // Zero wait states: write then read held back-to-back, then isolated read
    ifb.req = 1'b1; ifb.we = 1'b1; ifb.addr = 32'h10; ifb.wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    ifb.we = 1'b0; ifb.wdata = 32'h0;
    @(negedge clk);
    chk("w0_wr_ready", 32'(ifb.ready), 32'd1);
    chk("w0_wr_rdata", ifb.rdata,      32'd0);
    @(posedge clk); #1;
    ifb.req = 1'b0;
    @(negedge clk);
    chk("w0_b2b_ready", 32'(ifb.ready), 32'd1);
    chk("w0_b2b_rdata", ifb.rdata,      32'h5555_AAAA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_idle_busy", 32'(ifb.busy), 32'd0);
    @(posedge clk); #1;
    ifb.req = 1'b1;
    @(posedge clk); #1;
    ifb.req = 1'b0;
    @(negedge clk);
    chk("w0_rd_ready", 32'(ifb.ready), 32'd1);
    chk("w0_rd_rdata", ifb.rdata,      32'h5555_AAAA);
    @(posedge clk); #1;

    // Three wait states: req pulses during WAIT are dropped
    ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h0C;
    @(posedge clk); #1;
    ifc.req = 1'b0;
    nrdy = 0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ifc.ready) begin
        nrdy++;
        if (first == 0) first = k;
        chk("w3_err", 32'(ifc.err), 32'd0);
      end
      ifc.req = (k <= 3);
    end
    chk("w3_lat",    32'(first), 32'd4);
    chk("w3_nready", 32'(nrdy),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 5: the memory SHALL hold 2**DEPTH_LOG2 words of 32 bits each.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: this is the number of wait-state cycles inserted before each response.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge of clk.
REQ-004 Port rst, input, 1: reset, synchronous and active-low; the block SHALL be in reset on any rising clk edge that samples rst=0.
REQ-005 Port req, input, 1: request strobe from the initiator; sampled only when the block accepts requests (REQ-010).
REQ-006 Port we, input, 1: 1 = write, 0 = read; qualified by req.
REQ-007 Port addr, input, 32: byte address; the word index is addr[DEPTH_LOG2+1:2].
REQ-008 Port wdata, input, 32: write data; qualified by req and we.
REQ-009 Outputs:
- rdata, output, 32: read data, valid only while ready=1.
- ready, output, 1: single-cycle response strobe.
- err, output, 1: error flag, valid only while ready=1.
- busy, output, 1: set whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly three states, IDLE, WAIT and RESP, and SHALL accept a request on any edge where req=1 and the state is IDLE or RESP.
REQ-011 On acceptance the block SHALL latch we, addr and wdata into internal registers; later changes on those inputs SHALL have no effect on the transaction in flight.
REQ-012 Transitions when WAIT_CYCLES>0:
- IDLE->WAIT on acceptance.
- WAIT->RESP after exactly WAIT_CYCLES cycles in WAIT, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1 on acceptance.
REQ-013 Transitions when WAIT_CYCLES=0: IDLE->RESP on acceptance, with no WAIT cycles.
REQ-014 RESP SHALL last exactly one cycle; it SHALL go to IDLE if req=0 on that edge, otherwise it SHALL accept the new request and go to WAIT (or back to RESP when WAIT_CYCLES=0).
REQ-015 Latency: ready SHALL be 1 exactly in the (WAIT_CYCLES+1)-th cycle after the accepting edge, and 0 in every other cycle.
REQ-016 While the state is WAIT, req SHALL be ignored; there is no queueing and no response for a request dropped this way.
REQ-017 Error condition: a latched address with addr[1:0]!=0, or with addr[31:DEPTH_LOG2+2]!=0, SHALL set err=1 in the RESP cycle.
REQ-018 For an errored transaction the memory SHALL NOT be written and rdata SHALL be 32'h0.
REQ-019 Valid write: the memory word SHALL be updated with the latched wdata on the edge that ends RESP; in the RESP cycle itself rdata SHALL be 32'h0 and err SHALL be 0.
REQ-020 Valid read: rdata SHALL present the memory word at the latched index during RESP and SHALL reflect any write committed on an earlier edge.
REQ-021 Back-to-back accesses: a read accepted in the RESP cycle of a write to the same word SHALL return the newly written data.
REQ-022 Outside RESP, rdata and err SHALL be 0.

Reset
REQ-023 While reset is sampled, the block SHALL set state=IDLE, ready=0, err=0, busy=0, rdata=32'h0 and counter=0, and SHALL clear the latched request registers.
REQ-024 Reset in the middle of a transaction SHALL abandon it: no write is committed, no ready is produced, and the first request after reset is accepted normally.
REQ-025 Memory contents SHALL NOT be altered by reset and are undefined until written.
REQ-026 While rst=0, req SHALL be ignored.

Verification
REQ-027 Write then read (WAIT_CYCLES=2):
- Stimulus: write addr=0x8, wdata=0xDEADBEEF, then read addr=0x8.
- Response: each ready appears on the 3rd cycle after acceptance; the read returns rdata=0xDEADBEEF with err=0.
REQ-028 Back-to-back:
- Stimulus: hold req=1, issuing write addr=0x4, wdata=0x12345678, then read addr=0x4 accepted in the write's RESP cycle.
- Response: the read returns 0x12345678; busy stays 1 between the two transactions.
REQ-029 Misaligned address:
- Stimulus: write addr=0x6, wdata=0xFFFFFFFF, then read addr=0x4.
- Response: the first response has err=1 and rdata=0; the read returns the prior value of word 1, unchanged.
REQ-030 Out-of-range address (DEPTH_LOG2=5):
- Stimulus: read addr=0x80.
- Response: err=1, rdata=0.
- Stimulus: read addr=0x7C.
- Response: err=0.
REQ-031 Reset mid-transaction:
- Stimulus: accept write addr=0x0, wdata=0xA5A5A5A5; drive rst=0 for one edge during WAIT; then read addr=0x0.
- Response: no ready for the write; the read does not return 0xA5A5A5A5 unless word 0 held that value beforehand.
REQ-032 Zero wait states (WAIT_CYCLES=0):
- Stimulus: read accepted.
- Response: ready=1 in the first cycle after acceptance; req pulses during WAIT with WAIT_CYCLES=3 produce no extra responses.
